result_collector: RTL and testbench

Receiving end of the matrix engine's serialized result stream. The controller reads each result element from result memory and emits it as `CHUNKS` chunk beats. This block reassembles those beats into full-width words and buffers one frame of `ELEMS` words in order. It then presents them to the host through a valid/ready drain port. It sits between the controller's output side and the host/test harness.

---
 rtl/matmul_pkg.sv | 14 +
 rtl/result_fifo.sv | 78 +++++++
 rtl/result_collector.sv | 140 ++++++++++++++
 tb/tb_result_collector.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared constants and types for the matrix engine result path.
package matmul_pkg;

    localparam int ELEMS   = 9;
    localparam int CHUNK_W = 8;
    localparam int CHUNKS  = 3;
    localparam int W       = CHUNKS * CHUNK_W;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } frame_st_t;

endpackage

// File: rtl/result_fifo.sv
// Circular word buffer with a registered show-ahead head word and a sticky drop flag.
// A push into a full buffer is still accepted when a pop happens on the same edge.
module result_fifo #(
    parameter int DEPTH = 9,
    parameter int WIDTH = 24,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             empty,
    output logic             accepted,
    output logic             overflow,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             overflow_reg;
    logic [WIDTH-1:0] out_data_reg, head_next;
    logic             full;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign pop      = !empty && pop_ready;
    assign accepted = push && (!full || pop);

    always_comb begin
        wr_ptr_next = accepted ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg + CW'(accepted) - CW'(pop);
        // The word being written is the next head only when it lands where rd_ptr will point.
        head_next   = (accepted && (wr_ptr_reg == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (accepted && !clear) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            out_data_reg <= '0;
        end else if (clear) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            out_data_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_reg | (push && !accepted);
            out_data_reg <= head_next;
        end
    end

    assign overflow = overflow_reg;
    assign out_data = out_data_reg;

endmodule

// File: rtl/result_collector.sv
// Reassembles serial result beats into words and buffers one frame for the host.
// Optional feature macro: RESULT_CHECKSUM_EN (per-frame modulo-2^W sum on checksum).
module result_collector
    import matmul_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               ser_valid,
    input  logic [CHUNK_W-1:0] ser_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic               frame_done,
    output logic               overflow,
    output logic [W-1:0]       checksum
);

    localparam int CC_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int EC_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    logic [CC_W-1:0] chunk_cnt_reg;
    logic [EC_W-1:0] elem_cnt_reg;
    logic [W-1:0]    asm_reg;
    logic [W-1:0]    word;
    logic            word_done;
    logic            last_elem;
    logic            frame_fire;
    logic            frame_done_reg;
    logic            fifo_empty;
    logic            fifo_accepted;
    frame_st_t       frame_st_reg, frame_st_next;

    // Each beat lands in its own lane; the completed word is taken combinationally so it
    // can be pushed on the same edge as the final beat.
    generate
        for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_lane
            assign word[gi*CHUNK_W +: CHUNK_W] = (chunk_cnt_reg == CC_W'(gi)) ? ser_data
                                                 : asm_reg[gi*CHUNK_W +: CHUNK_W];
        end
    endgenerate

    assign word_done = ser_valid && (chunk_cnt_reg == CC_W'(CHUNKS - 1));
    assign last_elem = (elem_cnt_reg == EC_W'(ELEMS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chunk_cnt_reg <= '0;
            asm_reg       <= '0;
            elem_cnt_reg  <= '0;
        end else if (clear) begin
            chunk_cnt_reg <= '0;
            asm_reg       <= '0;
            elem_cnt_reg  <= '0;
        end else if (ser_valid) begin
            asm_reg       <= word;
            chunk_cnt_reg <= word_done ? '0 : chunk_cnt_reg + 1'b1;
            if (word_done) begin
                elem_cnt_reg <= last_elem ? '0 : elem_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_st_reg   <= IDLE;
            frame_done_reg <= 1'b0;
        end else if (clear) begin
            frame_st_reg   <= IDLE;
            frame_done_reg <= 1'b0;
        end else begin
            frame_st_reg   <= frame_st_next;
            frame_done_reg <= frame_fire;
        end
    end

    always_comb begin
        frame_st_next = frame_st_reg;
        case (frame_st_reg)
            IDLE:    if (ser_valid) frame_st_next = COLLECT;
            COLLECT: if (frame_fire) frame_st_next = IDLE;
            default: frame_st_next = IDLE;
        endcase
    end

    always_comb begin
        frame_fire = word_done && last_elem && (frame_st_reg == COLLECT);
    end

    result_fifo #(
        .DEPTH (ELEMS),
        .WIDTH (W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (word_done),
        .push_data (word),
        .pop_ready (out_ready),
        .empty     (fifo_empty),
        .accepted  (fifo_accepted),
        .overflow  (overflow),
        .out_data  (out_data)
    );

    assign out_valid  = !fifo_empty;
    assign frame_done = frame_done_reg;

`ifdef RESULT_CHECKSUM_EN
    logic [W-1:0] checksum_reg;
    logic         restart_reg;

    // The sum is held through the frame_done cycle and restarts on the next accepted word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_reg <= '0;
            restart_reg  <= 1'b0;
        end else if (clear) begin
            checksum_reg <= '0;
            restart_reg  <= 1'b0;
        end else begin
            if (fifo_accepted) begin
                checksum_reg <= (restart_reg ? '0 : checksum_reg) + word;
            end
            if (frame_fire) begin
                restart_reg <= 1'b1;
            end else if (fifo_accepted) begin
                restart_reg <= 1'b0;
            end
        end
    end

    assign checksum = checksum_reg;
`else
    logic unused_accepted;
    assign unused_accepted = fifo_accepted;
    assign checksum        = '0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Directed self-checking bench for result_collector with hand-computed expectations.
module tb_result_collector;
    import matmul_pkg::*;

    logic               clk;
    logic               rst;
    logic               clear;
    logic               ser_valid;
    logic [CHUNK_W-1:0] ser_data;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic               frame_done;
    logic               overflow;
    logic [W-1:0]       checksum;

    int total = 0;
    int bad   = 0;

`ifdef RESULT_CHECKSUM_EN
    localparam logic [31:0] CK45 = 32'd45;
    localparam logic [31:0] CK10 = 32'd10;
`else
    localparam logic [31:0] CK45 = 32'd0;
    localparam logic [31:0] CK10 = 32'd0;
`endif

    result_collector dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .frame_done (frame_done),
        .overflow   (overflow),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic beat(input logic [7:0] d);
        ser_valid = 1'b1;
        ser_data  = d;
        tick();
        ser_valid = 1'b0;
        ser_data  = '0;
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        beat(b0);
        beat(b1);
        beat(b2);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        clear     = 1'b0;
        ser_valid = 1'b0;
        ser_data  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_cksum", 32'(checksum), 32'd0);

        // Single word, one-cycle latency
        beat(8'h11);
        beat(8'h22);
        chk("single_pre", 32'(out_valid), 32'd0);
        beat(8'h33);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h332211);
        tick();
        chk("single_hold", 32'(out_data), 32'h332211);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_pop", 32'(out_valid), 32'd0);

        // Gapped beats
        do_clear();
        beat(8'hAA);
        for (int i = 0; i < 4; i++) tick();
        chk("gap_idle", 32'(out_valid), 32'd0);
        beat(8'hBB);
        tick();
        chk("gap_idle2", 32'(out_valid), 32'd0);
        beat(8'hCC);
        chk("gap_valid", 32'(out_valid), 32'd1);
        chk("gap_data", 32'(out_data), 32'hCCBBAA);

        // Full frame drained on the fly
        do_clear();
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            send_word(8'(n), 8'h00, 8'h00);
            chk("frame_data", 32'(out_data), 32'(n));
            chk("frame_valid", 32'(out_valid), 32'd1);
            chk("frame_fdone", 32'(frame_done), (n == 9) ? 32'd1 : 32'd0);
        end
        chk("frame_cksum", 32'(checksum), CK45);
        tick();
        chk("frame_fd_end", 32'(frame_done), 32'd0);
        chk("frame_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Overflow: tenth word dropped
        do_clear();
        for (int n = 1; n <= 10; n++) begin
            send_word(8'(n), 8'h00, 8'h00);
            if (n == 9) begin
                chk("ovf_fdone", 32'(frame_done), 32'd1);
                chk("ovf_cksum", 32'(checksum), CK45);
                chk("ovf_pre", 32'(overflow), 32'd0);
            end
        end
        chk("ovf_flag", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            chk("ovf_valid", 32'(out_valid), 32'd1);
            chk("ovf_drain", 32'(out_data), 32'(n));
            tick();
        end
        chk("ovf_empty", 32'(out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        out_ready = 1'b0;

        // Full buffer with a pop on the completing edge
        do_clear();
        chk("clr_ovf", 32'(overflow), 32'd0);
        for (int n = 1; n <= 9; n++) send_word(8'(n), 8'h00, 8'h00);
        beat(8'h0A);
        beat(8'h00);
        out_ready = 1'b1;
        beat(8'h00);
        out_ready = 1'b0;
        chk("fp_ovf", 32'(overflow), 32'd0);
        chk("fp_head", 32'(out_data), 32'd2);
        chk("fp_cksum", 32'(checksum), CK10);
        out_ready = 1'b1;
        for (int n = 2; n <= 10; n++) begin
            chk("fp_drain", 32'(out_data), 32'(n));
            tick();
        end
        chk("fp_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Asynchronous reset mid-word
        do_clear();
        send_word(8'h77, 8'h88, 8'h99);
        chk("ar_pre", 32'(out_data), 32'h998877);
        beat(8'h55);
        beat(8'h66);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_data", 32'(out_data), 32'd0);
        #1;
        rst = 1'b1;
        tick();
        send_word(8'h01, 8'h02, 8'h03);
        chk("ar_word_v", 32'(out_valid), 32'd1);
        chk("ar_word", 32'(out_data), 32'h030201);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
